// File: rtl/mul_accel_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mul_accel_pkg
//  Description : Shared constants for the iterative multiplier accelerator:
//                register address map, CTRL/STATUS bit positions and the
//                controller state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package mul_accel_pkg;

    // Register address map
    localparam logic [2:0] ADDR_OPA    = 3'd0;
    localparam logic [2:0] ADDR_OPB    = 3'd1;
    localparam logic [2:0] ADDR_CTRL   = 3'd2;
    localparam logic [2:0] ADDR_STATUS = 3'd3;
    localparam logic [2:0] ADDR_RES_LO = 3'd4;
    localparam logic [2:0] ADDR_RES_HI = 3'd5;

    // CTRL bit positions
    localparam int CTRL_GO_BIT     = 0;
    localparam int CTRL_SIGNED_BIT = 1;

    // STATUS bit positions
    localparam int STAT_DONE_BIT = 0;
    localparam int STAT_BUSY_BIT = 1;
    localparam int STAT_ERR_BIT  = 2;

    // Controller state encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : mul_accel_pkg
`default_nettype wire

// File: rtl/mul_iter_core.sv
`default_nettype none
// ============================================================================
//  Module      : mul_iter_core
//  Description : Radix-2 shift-add multiplier. Operands are captured as
//                magnitudes on start, WIDTH shift-add steps follow, and one
//                final cycle applies the sign and publishes the product.
//                The product register only changes at completion.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   signed_op,
    input  logic [WIDTH-1:0]       a,
    input  logic [WIDTH-1:0]       b,
    output logic                   busy,
    output logic                   done_pulse,
    output logic [2*WIDTH-1:0]     product
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_work;
    logic [2*WIDTH-1:0] r_product;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_neg;
    logic               r_run;

    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_step;
    logic [2*WIDTH-1:0] w_final;

    // Magnitudes; the most negative value maps to 2^(WIDTH-1), which still
    // fits as an unsigned WIDTH-bit number.
    assign w_a_mag = (signed_op && a[WIDTH-1]) ? (-a) : a;
    assign w_b_mag = (signed_op && b[WIDTH-1]) ? (-b) : b;

    // One step: conditionally add the multiplicand into the upper half, then
    // shift the {carry, upper, multiplier} chain right by one.
    assign w_sum  = {1'b0, r_work[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand};
    assign w_step = r_work[0] ? {w_sum, r_work[WIDTH-1:1]}
                              : {1'b0, r_work[2*WIDTH-1:1]};

    assign w_final = r_neg ? (-r_work) : r_work;

    // Operand capture, iteration and result publication
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand   <= '0;
            r_work    <= '0;
            r_product <= '0;
            r_cnt     <= '0;
            r_neg     <= 1'b0;
            r_run     <= 1'b0;
        end else if (start) begin
            r_mcand <= w_a_mag;
            r_work  <= {{WIDTH{1'b0}}, w_b_mag};
            r_neg   <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_cnt   <= CNT_W'(WIDTH);
            r_run   <= 1'b1;
        end else if (r_run) begin
            if (r_cnt != '0) begin
                r_work <= w_step;
                r_cnt  <= r_cnt - 1'b1;
            end else begin
                r_product <= w_final;
                r_run     <= 1'b0;
            end
        end
    end

    assign busy       = r_run;
    assign done_pulse = r_run && (r_cnt == '0);
    assign product    = r_product;

endmodule : mul_iter_core
`default_nettype wire

// File: rtl/mul_accel.sv
`default_nettype none
// ============================================================================
//  Module      : mul_accel
//  Description : Register-mapped multiplier accelerator. Holds the operand,
//                control and status registers, the address decode and the
//                IDLE/BUSY/DONE controller; the datapath lives in
//                mul_iter_core.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_accel
    import mul_accel_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [2:0]       addr,
    input  logic [WIDTH-1:0] wd,
    output logic [WIDTH-1:0] rd,
    output logic             irq
);

    state_t             r_state;
    logic [WIDTH-1:0]   r_opa;
    logic [WIDTH-1:0]   r_opb;
    logic               r_sgn;
    logic               r_err;
    logic               r_go_pend;

    logic               w_wr_opa;
    logic               w_wr_opb;
    logic               w_wr_ctrl;
    logic               w_wr_stat;
    logic               w_is_busy;
    logic               w_is_done;
    logic               w_go;
    logic               w_err_set;
    logic               w_core_busy;
    logic               w_core_done;
    logic [2*WIDTH-1:0] w_product;

    assign w_wr_opa  = we && (addr == ADDR_OPA);
    assign w_wr_opb  = we && (addr == ADDR_OPB);
    assign w_wr_ctrl = we && (addr == ADDR_CTRL);
    assign w_wr_stat = we && (addr == ADDR_STATUS);

    assign w_is_busy = (r_state == ST_BUSY);
    assign w_is_done = (r_state == ST_DONE);

    // A go is only honoured outside BUSY; any register write during BUSY
    // is dropped and flagged instead.
    assign w_go      = w_wr_ctrl && wd[CTRL_GO_BIT] && !w_is_busy;
    assign w_err_set = w_is_busy && (w_wr_opa || w_wr_opb || w_wr_ctrl);

    // The core captures operands on the go edge itself; the controller shows
    // BUSY from the following edge so BUSY lasts exactly WIDTH cycles.
    mul_iter_core #(
        .WIDTH      (WIDTH)
    ) u_core (
        .clk        (clk),
        .rst        (rst),
        .start      (w_go),
        .signed_op  (wd[CTRL_SIGNED_BIT]),
        .a          (r_opa),
        .b          (r_opb),
        .busy       (w_core_busy),
        .done_pulse (w_core_done),
        .product    (w_product)
    );

    // Register file, sticky error and controller state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_opa     <= '0;
            r_opb     <= '0;
            r_sgn     <= 1'b0;
            r_err     <= 1'b0;
            r_go_pend <= 1'b0;
        end else begin
            if (w_wr_opa && !w_is_busy) begin
                r_opa <= wd;
            end
            if (w_wr_opb && !w_is_busy) begin
                r_opb <= wd;
            end
            if (w_wr_ctrl && !w_is_busy) begin
                r_sgn <= wd[CTRL_SIGNED_BIT];
            end

            // A new error event wins over a simultaneous clear
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (w_wr_stat && wd[STAT_ERR_BIT]) begin
                r_err <= 1'b0;
            end

            if (w_go) begin
                r_state   <= ST_IDLE;
                r_go_pend <= 1'b1;
            end else if (r_go_pend) begin
                r_go_pend <= 1'b0;
                if (w_core_busy) begin
                    r_state <= ST_BUSY;
                end
            end else begin
                unique case (r_state)
                    ST_IDLE: r_state <= ST_IDLE;
                    ST_BUSY: begin
                        if (w_core_done) begin
                            r_state <= ST_DONE;
                        end
                    end
                    ST_DONE: r_state <= ST_DONE;
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    // Read-data multiplexer
    always_comb begin
        rd = '0;
        unique case (addr)
            ADDR_OPA:    rd = r_opa;
            ADDR_OPB:    rd = r_opb;
            ADDR_CTRL:   rd[CTRL_SIGNED_BIT] = r_sgn;
            ADDR_STATUS: begin
                rd[STAT_DONE_BIT] = w_is_done;
                rd[STAT_BUSY_BIT] = w_is_busy;
                rd[STAT_ERR_BIT]  = r_err;
            end
            ADDR_RES_LO: rd = w_product[WIDTH-1:0];
            ADDR_RES_HI: rd = w_product[2*WIDTH-1:WIDTH];
            default:     rd = '0;
        endcase
    end

    assign irq = w_is_done;

endmodule : mul_accel
`default_nettype wire
